instr_mem_sync: RTL

//   Parametrised, clocked instruction memory for the multi-cycle/pipelined core; successor to the

---
 rtl/instr_mem_sync.sv | 112 +++++++++++
 1 files changed

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: one-cycle registered fetch with alignment/range fault,
// plus a run-time program-load mode that rewrites words without re-elaboration.
module instr_mem_sync #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 64,
   parameter int                ADDR_W    = 32,
   parameter string             INIT_FILE = "program.txt",
   parameter logic [DATA_W-1:0] NOP       = {DATA_W{1'b0}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_req,
   input  logic [ADDR_W-1:0]          fetch_addr,
   output logic                       fetch_ready,
   output logic                       fetch_valid,
   output logic [DATA_W-1:0]          fetch_instr,
   output logic                       fetch_fault,
   input  logic                       prog_mode,
   input  logic                       load_en,
   input  logic [$clog2(DEPTH)-1:0]   load_addr,
   input  logic [DATA_W-1:0]          load_data,
   output logic [$clog2(DEPTH+1)-1:0] prog_count,
   output logic                       load_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PROG   = 2'd1,
      RESUME = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] word_idx;
   logic              fetch_bad;
   logic              accept;
   logic              load_in_range;
   logic              load_active;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_W'(DEPTH))
         return v;
      return v + CNT_W'(1);
   endfunction

   assign fetch_ready   = (state == RUN);
   assign accept        = fetch_req && fetch_ready;
   assign word_idx      = fetch_addr >> 2;
   assign fetch_bad     = (fetch_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH));
   assign load_in_range = ({1'b0, load_addr} < (IDX_W + 1)'(DEPTH));
   assign load_active   = (state == PROG) && load_en;

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (prog_mode) next_state = PROG;
         PROG:    if (!prog_mode) next_state = RESUME;
         RESUME:  next_state = prog_mode ? PROG : RUN;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RUN;
      else
         state <= next_state;
   end

   // Fetch stage: result registered one cycle after acceptance; holds when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_instr <= NOP;
         fetch_fault <= 1'b0;
      end else begin
         fetch_valid <= accept;
         if (accept) begin
            fetch_fault <= fetch_bad;
            fetch_instr <= fetch_bad ? NOP : mem[word_idx[IDX_W-1:0]];
         end
      end
   end

   // Load bookkeeping: counter and error flag restart only on entry from RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prog_count <= '0;
         load_err   <= 1'b0;
      end else if (state == RUN && next_state == PROG) begin
         prog_count <= '0;
         load_err   <= 1'b0;
      end else if (load_active) begin
         if (load_in_range)
            prog_count <= sat_inc(prog_count);
         else
            load_err <= 1'b1;
      end
   end

   // Array is deliberately outside the reset domain so a reset keeps loaded words.
   always_ff @(posedge clk) begin
      if (load_active && load_in_range)
         mem[load_addr] <= load_data;
   end

endmodule
